r2sdf_stage: RTL and testbench

- One radix-2 single-path delay-feedback (R2SDF, decimation-in-frequency) butterfly stage.
- Performs the stage's butterfly, feedback delay line, and twiddle multiply.
- Drives the address of the external real/imag twiddle coefficient ROM pair (1-cycle registered read) and consumes its output.
- Cascading stages with decreasing LD, all sharing TW_AW, forms the full 2^(TW_AW+1)-point FFT pipeline.

---
 rtl/r2sdf_stage.sv | 200 ++++++++++++++++++++
 tb/tb_r2sdf_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2sdf_stage.sv
// r2sdf_stage: one radix-2 single-path delay-feedback (DIF) FFT stage driving an external
// registered twiddle ROM pair. Define R2SDF_ROUND_EN for round-half-up instead of truncation.
module r2sdf_stage #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int LD    = 3,
  parameter int TW_AW = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  input  logic signed [DW-1:0]    in_re,
  input  logic signed [DW-1:0]    in_im,
  output logic        [TW_AW-1:0] coef_addr,
  input  logic signed [CW-1:0]    coef_re,
  input  logic signed [CW-1:0]    coef_im,
  output logic                    out_vld,
  output logic signed [DW-1:0]    out_re,
  output logic signed [DW-1:0]    out_im
);

  localparam int D  = 1 << LD;
  localparam int BW = DW + 2;       // butterfly sum plus rounding headroom
  localparam int PW = DW + CW;      // single product
  localparam int SW = PW + 2;       // product sum plus rounding headroom

  localparam logic signed [BW-1:0] B_ONE  = BW'(1);
  localparam logic signed [BW-1:0] B_MAX  = BW'((1 << (DW-1)) - 1);
  localparam logic signed [BW-1:0] B_MIN  = BW'(-(1 << (DW-1)));
  localparam logic signed [SW-1:0] S_HALF = SW'(64'sd1 <<< (CW-2));
  localparam logic signed [SW-1:0] S_MAX  = SW'((64'sd1 <<< (DW-1)) - 64'sd1);
  localparam logic signed [SW-1:0] S_MIN  = SW'(-(64'sd1 <<< (DW-1)));

  // Halve a butterfly sum/difference and clamp back into DW bits.
  function automatic logic signed [DW-1:0] half_sat(input logic signed [BW-1:0] v);
    logic signed [BW-1:0] r;
    r = v;
`ifdef R2SDF_ROUND_EN
    r = r + B_ONE;
`endif
    r = r >>> 1;
    if (r > B_MAX)      r = B_MAX;
    else if (r < B_MIN) r = B_MIN;
    return DW'(r);
  endfunction

  // Scale a Q1.(CW-1) product sum back to data precision and clamp.
  function automatic logic signed [DW-1:0] tw_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] r;
    r = v;
`ifdef R2SDF_ROUND_EN
    r = r + S_HALF;
`endif
    r = r >>> (CW-1);
    if (r > S_MAX)      r = S_MAX;
    else if (r < S_MIN) r = S_MIN;
    return DW'(r);
  endfunction

  // ---------------------------------------------------------------- counter
  logic [LD:0]   cnt;
  logic          phase;
  logic [LD-1:0] n;

  assign phase     = cnt[LD];
  assign n         = cnt[LD-1:0];
  assign coef_addr = TW_AW'(n) << (TW_AW - LD);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (in_vld) cnt <= cnt + 1'b1;
  end

  // ------------------------------------------------------------- delay line
  logic signed [DW-1:0] dl_re [D];
  logic signed [DW-1:0] dl_im [D];
  logic signed [DW-1:0] d_re, d_im;

  assign d_re = dl_re[D-1];
  assign d_im = dl_im[D-1];

  logic signed [BW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [DW-1:0] push_re, push_im, emit_re, emit_im;
  logic                 byp;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    sum_re  = BW'(d_re) + BW'(in_re);
    sum_im  = BW'(d_im) + BW'(in_im);
    dif_re  = BW'(d_re) - BW'(in_re);
    dif_im  = BW'(d_im) - BW'(in_im);
    push_re = in_re;
    push_im = in_im;
    emit_re = d_re;
    emit_im = d_im;
    byp     = phase || (n == '0);
    if (phase) begin
      push_re = half_sat(dif_re);
      push_im = half_sat(dif_im);
      emit_re = half_sat(sum_re);
      emit_im = half_sat(sum_im);
    end
  end

  // NOTE: the delay line is built from flops, so it takes the async reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D; k++) begin
        dl_re[k] <= '0;
        dl_im[k] <= '0;
      end
    end else if (in_vld) begin
      dl_re[0] <= push_re;
      dl_im[0] <= push_im;
      for (int k = 1; k < D; k++) begin
        dl_re[k] <= dl_re[k-1];
        dl_im[k] <= dl_im[k-1];
      end
    end
  end

  // ------------------------------------------------- E0: butterfly capture
  // The first fill block after reset carries no data; primed opens the output.
  logic                 primed;
  logic                 s0_vld, s0_byp;
  logic signed [DW-1:0] s0_re, s0_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= 1'b0;
      s0_vld <= 1'b0;
      s0_byp <= 1'b0;
      s0_re  <= '0;
      s0_im  <= '0;
    end else begin
      primed <= primed | (in_vld & phase);
      s0_vld <= in_vld & (primed | phase);
      if (in_vld) begin
        s0_byp <= byp;
        s0_re  <= emit_re;
        s0_im  <= emit_im;
      end
    end
  end

  // ------------------------------------------------------ E1: products
  // ROM words for this sample appear now, one cycle after the address.
  logic                 s1_vld, s1_byp;
  logic signed [DW-1:0] s1_re, s1_im;
  logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_byp <= 1'b0;
      s1_re  <= '0;
      s1_im  <= '0;
      p_rc   <= '0;
      p_is   <= '0;
      p_ic   <= '0;
      p_rs   <= '0;
    end else begin
      s1_vld <= s0_vld;
      if (s0_vld) begin
        s1_byp <= s0_byp;
        s1_re  <= s0_re;
        s1_im  <= s0_im;
        p_rc   <= PW'(s0_re) * PW'(coef_re);
        p_is   <= PW'(s0_im) * PW'(coef_im);
        p_ic   <= PW'(s0_im) * PW'(coef_re);
        p_rs   <= PW'(s0_re) * PW'(coef_im);
      end
    end
  end

  // --------------------------------------------- E2: combine and saturate
  // Multiply by conj-rotation W = c - j*s.
  logic signed [DW-1:0] tw_re, tw_im;

  always_comb begin
    tw_re = tw_sat(SW'(p_rc) + SW'(p_is));
    tw_im = tw_sat(SW'(p_ic) - SW'(p_rs));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_re  <= '0;
      out_im  <= '0;
    end else begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_re <= s1_byp ? s1_re : tw_re;
        out_im <= s1_byp ? s1_im : tw_im;
      end
    end
  end

endmodule

// File: tb/tb_r2sdf_stage.sv
// tb_r2sdf_stage: directed plus randomized checks of r2sdf_stage against a block-level
// reference model; honours R2SDF_ROUND_EN when the build defines it.
module tb_r2sdf_stage;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int LD    = 3;
  localparam int TW_AW = 8;
  localparam int D     = 1 << LD;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    in_vld = 1'b0;
  logic signed [DW-1:0]    in_re = '0;
  logic signed [DW-1:0]    in_im = '0;
  logic        [TW_AW-1:0] coef_addr;
  logic signed [CW-1:0]    coef_re = '0;
  logic signed [CW-1:0]    coef_im = '0;
  logic                    out_vld;
  logic signed [DW-1:0]    out_re;
  logic signed [DW-1:0]    out_im;

  r2sdf_stage #(.DW(DW), .CW(CW), .LD(LD), .TW_AW(TW_AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_re(in_re), .in_im(in_im),
    .coef_addr(coef_addr), .coef_re(coef_re), .coef_im(coef_im),
    .out_vld(out_vld), .out_re(out_re), .out_im(out_im)
  );

  always #5 clk = ~clk;

  // Twiddle ROM pair: word k = round(32767 * cos/sin(pi*k/256)), one-cycle read.
  int cos_tab [1 << TW_AW];
  int sin_tab [1 << TW_AW];
  bit rom_force = 1'b0;

  always_ff @(posedge clk) begin
    coef_re <= rom_force ? CW'(32767) : CW'(cos_tab[coef_addr]);
    coef_im <= rom_force ? CW'(32767) : CW'(sin_tab[coef_addr]);
  end

  typedef struct { bit vld; int re; int im; } exp_t;

  int   hx_re[$], hx_im[$];   // every accepted input since reset
  int   hf_re[$], hf_im[$];   // value fed back into the delay for that input
  int   got_re[$], got_im[$];
  exp_t pipe [3];
  int   total = 0;
  int   bad = 0;

  function automatic longint shr(input longint v, input int sh);
    longint r = v;
`ifdef R2SDF_ROUND_EN
    r = r + (64'sd1 <<< (sh - 1));
`endif
    return r >>> sh;
  endfunction

  function automatic int sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Sample i of the stream: phase 1 combines with sample i-D, phase 0 rotates what
  // the previous phase 1 fed back D samples earlier (zero for the very first block).
  task automatic model_step(input int xr, input int xi, output exp_t e);
    int i, p, nn, dr, di, fr, fi, c, s;
    i = hx_re.size();
    p = i % (2 * D);
    nn = p % D;
    fr = 0; fi = 0;
    e.vld = (i >= D);
    if (p >= D) begin
      dr = hx_re[i-D]; di = hx_im[i-D];
      e.re = sat(shr(longint'(dr) + xr, 1));
      e.im = sat(shr(longint'(di) + xi, 1));
      fr = sat(shr(longint'(dr) - xr, 1));
      fi = sat(shr(longint'(di) - xi, 1));
    end else begin
      dr = (i < D) ? 0 : hf_re[i-D];
      di = (i < D) ? 0 : hf_im[i-D];
      if (nn == 0) begin
        e.re = dr; e.im = di;
      end else begin
        c = rom_force ? 32767 : cos_tab[nn << (TW_AW - LD)];
        s = rom_force ? 32767 : sin_tab[nn << (TW_AW - LD)];
        e.re = sat(shr(longint'(dr) * c + longint'(di) * s, CW - 1));
        e.im = sat(shr(longint'(di) * c - longint'(dr) * s, CW - 1));
      end
    end
    hx_re.push_back(xr); hx_im.push_back(xi);
    hf_re.push_back(fr); hf_im.push_back(fi);
  endtask

  task automatic cycle(input bit v, input int xr, input int xi);
    exp_t e;
    int   ea;
    e.vld = 1'b0; e.re = 0; e.im = 0;
    in_vld = v;
    in_re  = DW'(xr);
    in_im  = DW'(xi);
    if (v) model_step(xr, xi, e);
    @(posedge clk);
    #1;
    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
    total++;
    assert (out_vld === pipe[2].vld) else begin
      bad++; $error("FAIL out_vld: got %0b want %0b", out_vld, pipe[2].vld);
    end
    if (pipe[2].vld) begin
      total++;
      assert (int'(out_re) === pipe[2].re && int'(out_im) === pipe[2].im) else begin
        bad++; $error("FAIL out_data: got (%0d,%0d) want (%0d,%0d)",
                      out_re, out_im, pipe[2].re, pipe[2].im);
      end
    end
    if (out_vld === 1'b1) begin
      got_re.push_back(int'(out_re)); got_im.push_back(int'(out_im));
    end
    ea = ((hx_re.size() % (2 * D)) % D) << (TW_AW - LD);
    total++;
    assert (coef_addr === TW_AW'(ea)) else begin
      bad++; $error("FAIL coef_addr: got %0d want %0d", coef_addr, ea);
    end
  endtask

  task automatic feed(input int xr, input int xi, input int gmin, input int gmax);
    repeat (int'($urandom_range(gmax, gmin))) cycle(1'b0, 0, 0);
    cycle(1'b1, xr, xi);
  endtask

  task automatic flush();
    repeat (4) cycle(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    in_vld = 1'b0; in_re = '0; in_im = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    assert (out_vld === 1'b0 && out_re === '0 && out_im === '0 && coef_addr === '0) else begin
      bad++; $error("FAIL reset_outs: got vld=%0b re=%0d im=%0d addr=%0d want all 0",
                    out_vld, out_re, out_im, coef_addr);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    total++;
    assert (coef_addr === '0) else begin
      bad++; $error("FAIL reset_addr: got %0d want 0", coef_addr);
    end
    hx_re.delete(); hx_im.delete(); hf_re.delete(); hf_im.delete();
    got_re.delete(); got_im.delete();
    for (int k = 0; k < 3; k++) pipe[k] = '{vld: 1'b0, re: 0, im: 0};
  endtask

  task automatic chk_got(input string tag, input int idx, input int er, input int ei,
                         input int tol);
    int ar, ai;
    ar = (idx < got_re.size()) ? got_re[idx] : 99999;
    ai = (idx < got_im.size()) ? got_im[idx] : 99999;
    total++;
    assert (((ar - er) <= tol && (er - ar) <= tol && (ai - ei) <= tol && (ei - ai) <= tol)
            === 1'b1) else begin
      bad++; $error("FAIL %s[%0d]: got (%0d,%0d) want (%0d,%0d) +/-%0d",
                    tag, idx, ar, ai, er, ei, tol);
    end
  endtask

  task automatic chk_count(input string tag, input int want);
    total++;
    assert (got_re.size() === want) else begin
      bad++; $error("FAIL %s: got %0d outputs want %0d", tag, got_re.size(), want);
    end
  endtask

  initial begin
    real pi;
    int  rnd;
    pi = 3.14159265358979323846;
    for (int k = 0; k < (1 << TW_AW); k++) begin
      cos_tab[k] = int'(32767.0 * $cos(pi * k / (1 << TW_AW)));
      sin_tab[k] = int'(32767.0 * $sin(pi * k / (1 << TW_AW)));
    end

    // Reset state
    do_reset();

    // Impulse, two blocks
    for (int k = 0; k < 4 * D; k++) cycle(1'b1, (k == 0) ? 1000 : 0, 0);
    flush();
    chk_count("imp_count", 3 * D);
    chk_got("imp_p1_n0", 0, 500, 0, 0);
    chk_got("imp_p1_n1", 1, 0, 0, 0);
    chk_got("imp_b2_n0", D, 500, 0, 0);
    chk_got("imp_b2_n4", D + 4, 0, 0, 0);

    // Full fill block of 1000 then zeros: feedback 500 on every slot
    do_reset();
    for (int k = 0; k < 4 * D; k++) cycle(1'b1, (k < D) ? 1000 : 0, 0);
    flush();
    for (int k = 0; k < D; k++) chk_got("fill_p1", k, 500, 0, 0);
    chk_got("fill_b2_n0", D, 500, 0, 0);
    chk_got("fill_b2_n2", D + 2, 354, -354, 1);
    chk_got("fill_b2_n4", D + 4, 0, -500, 1);

    // Constant input, contiguous then with 1-3 cycle gaps
    for (int g = 0; g < 2; g++) begin
      do_reset();
      for (int k = 0; k < 3 * D; k++) feed(2000, -2000, (g == 0) ? 0 : 1, (g == 0) ? 0 : 3);
      flush();
      chk_count("const_count", 2 * D);
      for (int k = 0; k < D; k++) chk_got("const_p1", k, 2000, -2000, 0);
      for (int k = D; k < 2 * D; k++) chk_got("const_p0", k, 0, 0, 0);
    end

    // Saturating twiddle with forced full-scale coefficients
    do_reset();
    rom_force = 1'b1;
    for (int k = 0; k < D; k++) cycle(1'b1, 32767, 32767);
    for (int k = 0; k < D; k++) cycle(1'b1, -32767, -32767);
    for (int k = 0; k < D; k++) cycle(1'b1, 0, 0);
    flush();
    rom_force = 1'b0;
    chk_got("sat_p1", 0, 0, 0, 0);
    chk_got("sat_byp", D, 32767, 32767, 0);
    for (int k = D + 1; k < 2 * D; k++) chk_got("sat_tw", k, 32767, 0, 1);

    // Butterfly rounding of d=1, x=0
    do_reset();
    for (int k = 0; k < 2 * D; k++) cycle(1'b1, (k < D) ? 1 : 0, 0);
    flush();
`ifdef R2SDF_ROUND_EN
    chk_got("round_half", 0, 1, 0, 0);
`else
    chk_got("round_half", 0, 0, 0, 0);
`endif

    // Random data with random gaps
    do_reset();
    for (int k = 0; k < 300; k++) begin
      rnd = int'($urandom_range(65535)) - 32768;
      feed(rnd, int'($urandom_range(65535)) - 32768, 0, ($urandom_range(3) == 0) ? 2 : 0);
    end
    flush();
    chk_count("rand_count", 300 - D);

    // Reset at cnt=5 of block 2, then re-prime
    do_reset();
    for (int k = 0; k < 2 * D + 5; k++)
      cycle(1'b1, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    do_reset();
    for (int k = 0; k < 2 * D; k++)
      cycle(1'b1, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    flush();
    chk_count("rearm_count", D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
